// File: rtl/d_mem_pkg.sv
// Shared encodings, FSM states and byte-lane helper
// for the sized data memory.
package d_mem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   function automatic logic [3:0] byte_en(
      input logic [1:0] size,
      input logic [1:0] lane
   );
      logic [3:0] be;
      be = 4'b0000;
      unique case (1'b1)
         size == SIZE_B: be = 4'b0001 << lane;
         size == SIZE_H: be = lane[1] ? 4'b1100 : 4'b0011;
         size == SIZE_W: be = 4'b1111;
         default:        be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/d_mem_load_align.sv
// Load lane extraction with sign or zero extension.
// Purely combinational.
module d_mem_load_align
   import d_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      b      = word[{lane, 3'b000} +: 8];
      h      = lane[1] ? word[31:16] : word[15:0];
      result = 32'd0;
      unique case (1'b1)
         size == SIZE_B: result = {{24{b[7] & ~uns}}, b};
         size == SIZE_H: result = {{16{h[15] & ~uns}}, h};
         size == SIZE_W: result = word;
         default:        result = 32'd0;
      endcase
   end

endmodule

// File: rtl/d_mem_sized.sv
// Byte/half/word data memory with request/Ready
// handshake, wait states and access-error detection.
module d_mem_sized
   import d_mem_pkg::*;
#(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter string       INIT_FILE   = ""
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   input  logic [1:0]  MemSize,
   input  logic        MemUnsigned,
   output logic [31:0] ReadData,
   output logic        Ready,
   output logic        AccessError,
   output logic        Busy
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [3:0] WLAST =
      4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

   logic [31:0] mem [DEPTH];

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic [3:0]    be;
   logic [31:0]   wdata;
   logic          req;
   logic          accept;
   logic          bad;

   logic [1:0]  lane_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        ld_q;
   logic        err_q;
   logic [31:0] word_q;

   logic [31:0] src_word;
   logic [1:0]  src_lane;
   logic [1:0]  src_size;
   logic        src_uns;
   logic        src_ld;
   logic        src_err;
   logic [31:0] aligned;

   state_t     state, state_n;
   logic [3:0] cnt, cnt_n;

   assign off    = Address - BASE_ADDR;
   assign idx    = off[AW+1:2];
   assign lane   = off[1:0];
   assign req    = MemRead | MemWrite;
   assign accept = (state == IDLE) & req & ~Reset;
   assign be     = byte_en(MemSize, lane);

   always_comb begin
      bad = 1'b0;
      unique case (1'b1)
         MemSize == SIZE_B: bad = 1'b0;
         MemSize == SIZE_H: bad = lane[0];
         MemSize == SIZE_W: bad = |lane;
         default:           bad = 1'b1;
      endcase
      if ((off >> (AW + 2)) != 32'd0)
         bad = 1'b1;
      if (MemRead & MemWrite)
         bad = 1'b1;
   end

   always_comb begin
      wdata = WriteData;
      unique case (1'b1)
         MemSize == SIZE_B: wdata = {4{WriteData[7:0]}};
         MemSize == SIZE_H: wdata = {2{WriteData[15:0]}};
         default:           wdata = WriteData;
      endcase
   end

   // Stores commit at the accept edge; the array itself is never reset
   always_ff @(posedge Clock) begin
      if (accept && MemWrite && !bad) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b])
               mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         lane_q <= 2'b00;
         size_q <= 2'b00;
         uns_q  <= 1'b0;
         ld_q   <= 1'b0;
         err_q  <= 1'b0;
         word_q <= 32'd0;
      end else if (accept) begin
         lane_q <= lane;
         size_q <= MemSize;
         uns_q  <= MemUnsigned;
         ld_q   <= MemRead & ~MemWrite;
         err_q  <= bad;
         word_q <= mem[idx];
      end
   end

   // With no wait states RESP is entered on the accept edge itself
   always_comb begin
      if (state == IDLE) begin
         src_word = mem[idx];
         src_lane = lane;
         src_size = MemSize;
         src_uns  = MemUnsigned;
         src_ld   = MemRead & ~MemWrite;
         src_err  = bad;
      end else begin
         src_word = word_q;
         src_lane = lane_q;
         src_size = size_q;
         src_uns  = uns_q;
         src_ld   = ld_q;
         src_err  = err_q;
      end
   end

   d_mem_load_align u_align (
      .word   (src_word),
      .lane   (src_lane),
      .size   (src_size),
      .uns    (src_uns),
      .result (aligned)
   );

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE: begin
            if (accept) begin
               cnt_n   = 4'd0;
               state_n = (WAIT_STATES == 0) ? RESP : WAIT;
            end
         end
         WAIT: begin
            if (cnt == WLAST)
               state_n = RESP;
            else
               cnt_n = cnt + 4'd1;
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         ReadData <= 32'd0;
      end else if (state_n == RESP && state != RESP) begin
         if (src_err)
            ReadData <= 32'd0;
         else if (src_ld)
            ReadData <= aligned;
      end
   end

   assign Ready       = (state == RESP);
   assign AccessError = (state == RESP) & err_q;
   assign Busy        = (state != IDLE);

endmodule

// File: tb/tb_d_mem_sized.sv
// Directed and random checks of d_mem_sized against a
// byte-array reference model, at 0 and 3 wait states.
module tb_d_mem_sized;

   logic        Clock;
   logic        Reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [1:0]  MemSize;
   logic        MemUnsigned;
   logic        MemWriteT, MemReadT;
   logic        sel;

   logic [31:0] rdata0, rdata3;
   logic        ready0, ready3, aerr0, aerr3, busy0, busy3;

   logic [31:0] s_rdata;
   logic        s_ready, s_aerr, s_busy;

   int nchecks = 0;
   int nerr    = 0;

   logic [7:0]  mm [2][256];
   logic [31:0] lastrd [2];
   logic [31:0] base [2];
   int          ws [2];

   d_mem_sized #(
      .DEPTH(64), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0000)
   ) u_d0 (
      .Clock(Clock), .Reset(Reset), .Address(Address),
      .WriteData(WriteData), .MemWrite(MemWriteT & ~sel),
      .MemRead(MemReadT & ~sel), .MemSize(MemSize),
      .MemUnsigned(MemUnsigned), .ReadData(rdata0),
      .Ready(ready0), .AccessError(aerr0), .Busy(busy0)
   );

   d_mem_sized #(
      .DEPTH(64), .WAIT_STATES(3), .BASE_ADDR(32'h0000_1000)
   ) u_d3 (
      .Clock(Clock), .Reset(Reset), .Address(Address),
      .WriteData(WriteData), .MemWrite(MemWriteT & sel),
      .MemRead(MemReadT & sel), .MemSize(MemSize),
      .MemUnsigned(MemUnsigned), .ReadData(rdata3),
      .Ready(ready3), .AccessError(aerr3), .Busy(busy3)
   );

   assign s_rdata = sel ? rdata3 : rdata0;
   assign s_ready = sel ? ready3 : ready0;
   assign s_aerr  = sel ? aerr3  : aerr0;
   assign s_busy  = sel ? busy3  : busy0;

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchecks++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: byte-addressed little-endian array, plain arithmetic
   task automatic model(input int d, input bit wr, input bit rd,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output bit e, output logic [31:0] r);
      logic [31:0] offs;
      logic [31:0] v;
      int n;
      offs = a - base[d];
      n = 1 << sz;
      e = (sz == 2'b11) || (sz == 2'b01 && (a % 2) != 0) ||
          (sz == 2'b10 && (a % 4) != 0) || (offs >= 256) ||
          (rd && wr);
      if (e) begin
         r = 32'd0;
      end else if (rd) begin
         v = 32'd0;
         for (int i = 0; i < n; i++)
            v = v | (32'(mm[d][offs + i]) << (8 * i));
         if (!uns && n < 4 && v[8*n-1])
            v = v | ~((32'd1 << (8 * n)) - 32'd1);
         r = v;
      end else begin
         for (int i = 0; i < n; i++)
            mm[d][offs + i] = 8'((wd >> (8 * i)) & 32'hFF);
         r = lastrd[d];
      end
      lastrd[d] = r;
   endtask

   task automatic access(input int d, input bit wr, input bit rd,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input bit noisy, input string tag);
      bit e;
      logic [31:0] r;
      int n;
      bit seen;
      model(d, wr, rd, sz, uns, a, wd, e, r);
      @(negedge Clock);
      sel = (d != 0);
      Address = a;
      WriteData = wd;
      MemSize = sz;
      MemUnsigned = uns;
      MemWriteT = wr;
      MemReadT = rd;
      @(posedge Clock);
      #1;
      MemWriteT = 1'b0;
      MemReadT = 1'b0;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         if (s_ready) begin
            seen = 1'b1;
         end else begin
            chk({tag, ":busy_wait"}, 32'(s_busy), 32'd1);
            if (noisy && ws[d] > 0) begin
               Address = base[d] + 32'($urandom_range(0, 63) << 2);
               WriteData = $urandom;
               MemSize = 2'b10;
               MemWriteT = 1'b1;
            end
            @(posedge Clock);
            #1;
            n++;
         end
      end
      MemWriteT = 1'b0;
      MemReadT = 1'b0;
      chk({tag, ":latency"}, 32'(n), 32'(ws[d]));
      chk({tag, ":busy_ready"}, 32'(s_busy), 32'd1);
      chk({tag, ":error"}, 32'(s_aerr), 32'(e));
      chk({tag, ":rdata"}, s_rdata, r);
      @(posedge Clock);
      #1;
      chk({tag, ":ready_pulse"}, 32'(s_ready), 32'd0);
      chk({tag, ":busy_end"}, 32'(s_busy), 32'd0);
   endtask

   initial begin
      bit e;
      logic [31:0] r;
      logic [31:0] a;
      logic [1:0]  sz;
      int kind;
      int offs;
      bit wr, rd;

      base[0] = 32'h0000_0000;
      base[1] = 32'h0000_1000;
      ws[0] = 0;
      ws[1] = 3;
      lastrd[0] = 32'd0;
      lastrd[1] = 32'd0;
      for (int i = 0; i < 256; i++) begin
         mm[0][i] = 8'h00;
         mm[1][i] = 8'h00;
      end

      Reset = 1'b1;
      sel = 1'b0;
      Address = 32'd0;
      WriteData = 32'd0;
      MemSize = 2'b10;
      MemUnsigned = 1'b0;
      MemWriteT = 1'b0;
      MemReadT = 1'b0;
      #7;
      chk("rst:rdata0", rdata0, 32'd0);
      chk("rst:rdata3", rdata3, 32'd0);
      chk("rst:flags0", {29'd0, ready0, aerr0, busy0}, 32'd0);
      chk("rst:flags3", {29'd0, ready3, aerr3, busy3}, 32'd0);
      @(negedge Clock);
      Reset = 1'b0;

      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 64; w++)
            access(d, 1, 0, 2'b10, 0, base[d] + 32'(4 * w), $urandom,
                   0, "preload");

      access(0, 1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, "sw10");
      access(0, 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, "lw10");
      access(0, 1, 0, 2'b00, 0, 32'h11, 32'h7F, 0, "sb11");
      access(0, 1, 0, 2'b00, 0, 32'h12, 32'h80, 0, "sb12");
      access(0, 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, "lw10b");
      access(0, 0, 1, 2'b00, 0, 32'h12, 32'h0, 0, "lb12");
      access(0, 0, 1, 2'b00, 1, 32'h12, 32'h0, 0, "lbu12");
      access(0, 1, 0, 2'b01, 0, 32'h16, 32'hA55A, 0, "sh16");
      access(0, 0, 1, 2'b01, 0, 32'h16, 32'h0, 0, "lh16");
      access(0, 0, 1, 2'b01, 1, 32'h16, 32'h0, 0, "lhu16");
      access(0, 0, 1, 2'b10, 0, 32'h14, 32'h0, 0, "lw14");

      access(0, 0, 1, 2'b01, 0, 32'h13, 32'h0, 0, "err_lh13");
      access(0, 1, 0, 2'b10, 0, 32'h0E, 32'h11111111, 0, "err_sw0e");
      access(0, 1, 0, 2'b11, 0, 32'h10, 32'h22222222, 0, "err_size");
      access(0, 1, 0, 2'b10, 0, 32'h100, 32'h33333333, 0, "err_range");
      access(0, 1, 1, 2'b10, 0, 32'h10, 32'h44444444, 0, "err_rdwr");
      access(0, 0, 1, 2'b10, 0, 32'h0C, 32'h0, 0, "lw0c");
      access(0, 0, 1, 2'b10, 0, 32'h10, 32'h0, 0, "lw10c");

      access(1, 1, 0, 2'b10, 0, 32'h1010, 32'hCAFEF00D, 1, "ws3_sw");
      access(1, 0, 1, 2'b10, 0, 32'h1010, 32'h0, 1, "ws3_lw");
      access(1, 0, 1, 2'b00, 0, 32'h1013, 32'h0, 1, "ws3_lb");
      access(1, 0, 1, 2'b10, 0, 32'h0FFC, 32'h0, 0, "ws3_below");

      // Asynchronous reset in WAIT after a store has been accepted
      model(1, 1, 0, 2'b10, 0, 32'h1020, 32'h12345678, e, r);
      @(negedge Clock);
      sel = 1'b1;
      Address = 32'h1020;
      WriteData = 32'h12345678;
      MemSize = 2'b10;
      MemWriteT = 1'b1;
      @(posedge Clock);
      #1;
      MemWriteT = 1'b0;
      chk("rstmid:busy_before", 32'(busy3), 32'd1);
      #2;
      Reset = 1'b1;
      #1;
      chk("rstmid:busy", 32'(busy3), 32'd0);
      chk("rstmid:ready", 32'(ready3), 32'd0);
      chk("rstmid:rdata3", rdata3, 32'd0);
      chk("rstmid:rdata0", rdata0, 32'd0);
      lastrd[0] = 32'd0;
      lastrd[1] = 32'd0;
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge Clock);
         #1;
         chk("rstmid:no_ready", 32'(ready3), 32'd0);
      end
      access(1, 0, 1, 2'b10, 0, 32'h1020, 32'h0, 0, "rstmid_lw");

      for (int it = 0; it < 300; it++) begin
         for (int d = 0; d < 2; d++) begin
            kind = $urandom_range(0, 19);
            sz = (kind == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            offs = $urandom_range(0, 255);
            if (sz != 2'b11 && $urandom_range(0, 9) != 0)
               offs = offs & ~((1 << sz) - 1);
            a = base[d] + 32'(offs);
            if (kind == 2)
               a = base[d] + 32'd256 + 32'(offs);
            if (kind == 3)
               a = base[d] - 32'd4;
            wr = ($urandom_range(0, 1) == 1);
            rd = !wr;
            if (kind == 4) begin
               wr = 1'b1;
               rd = 1'b1;
            end
            access(d, wr, rd, sz, 1'($urandom_range(0, 1)), a,
                   $urandom, ($urandom_range(0, 1) == 1), "rand");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerr);
      $finish;
   end

endmodule
